// File: rtl/tt_mux_ctrl_pkg.sv
// rtl/tt_mux_ctrl_pkg.sv - shared types and bus field offsets for the project mux controller
// Purpose: switch-sequence state enum, project bus widths, iw/ow field offsets.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISOLATE = 2'd1,
        ST_RESET   = 2'd2,
        ST_ACTIVE  = 2'd3
    } state_e;

    localparam int IW_W = 18;
    localparam int OW_W = 24;

    // iw field offsets
    localparam int IW_CLK    = 0;
    localparam int IW_RST    = 1;
    localparam int IW_UI_LO  = 2;
    localparam int IW_UIO_LO = 10;

    // ow field offsets
    localparam int OW_UO_LO      = 0;
    localparam int OW_UIO_OUT_LO = 8;
    localparam int OW_UIO_OE_LO  = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_mux_ctrl_if.sv
// rtl/tt_mux_ctrl_if.sv - selection request handshake and status bundle
// Ports: sel_valid/sel_en/sel_addr (request), sel_ready (accept),
//        sel_err/busy/cur_addr/cur_active (status back to the requester).
interface tt_mux_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              sel_valid;
    logic              sel_ready;
    logic              sel_en;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;
    logic              busy;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_active;

    modport master (
        output sel_valid, sel_en, sel_addr,
        input  sel_ready, sel_err, busy, cur_addr, cur_active
    );

    modport slave (
        input  sel_valid, sel_en, sel_addr,
        output sel_ready, sel_err, busy, cur_addr, cur_active
    );
endinterface

// File: rtl/tt_mux_ctrl_ow_sel.sv
// rtl/tt_mux_ctrl_ow_sel.sv - registered N_PROJ:1 project output mux with zero-force
// Ports: clk, rst_n (async active-low); sel_addr/sel_active choose the slice;
//        ow_all concatenated project outputs; uo_out/uio_out/uio_oe registered result.
module tt_mux_ow_sel
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      sel_addr,
    input  logic                   sel_active,
    input  logic [OW_W*N_PROJ-1:0] ow_all,
    output logic [7:0]             uo_out,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe
);

    logic [OW_W-1:0] ow_d, ow_q;

    // Outputs idle (including uio_oe=0) whenever no project is fully active.
    always_comb begin
        ow_d = '0;
        if (sel_active) begin
            for (int i = 0; i < N_PROJ; i++) begin
                if (sel_addr == ADDR_W'(i)) begin
                    ow_d = ow_all[i*OW_W +: OW_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ow_q <= '0;
        end else begin
            ow_q <= ow_d;
        end
    end

    assign uo_out  = ow_q[OW_UO_LO      +: 8];
    assign uio_out = ow_q[OW_UIO_OUT_LO +: 8];
    assign uio_oe  = ow_q[OW_UIO_OE_LO  +: 8];

endmodule

// File: rtl/tt_mux_ctrl.sv
// rtl/tt_mux_ctrl.sv - project selection controller: isolate, reset, release sequencing
// Ports: clk, rst_n (async active-low); sel (request/status interface);
//        ui_in/uio_in/proj_rst_n pad inputs; iw broadcast project input bus;
//        ena one-hot-or-zero enables; ow_all project outputs; uo_out/uio_out/uio_oe muxed outputs.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ     = 32,
    parameter int ADDR_W     = 5,
    parameter int ISO_CYCLES = 4,
    parameter int RST_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tt_mux_ctrl_if.slave           sel,
    input  logic [7:0]             ui_in,
    input  logic [7:0]             uio_in,
    input  logic                   proj_rst_n,
    output logic [IW_W-1:0]        iw,
    output logic [N_PROJ-1:0]      ena,
    input  logic [OW_W*N_PROJ-1:0] ow_all,
    output logic [7:0]             uo_out,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe
);

    localparam int CNT_W = $clog2(max_int(ISO_CYCLES, RST_CYCLES) + 1);
    // Counters load N-1 on state entry and leave when they reach zero,
    // so each phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

    state_e            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [ADDR_W-1:0] tgt_d, tgt_q;
    logic [N_PROJ-1:0] ena_d, ena_q;
    logic              err_d, err_q;

    logic              ready;
    logic              accept;
    logic              addr_ok;
    logic              is_active;
    logic              pass_in;
    logic [ADDR_W-1:0] cur_addr;

    assign ready     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign accept    = sel.sel_valid && ready;
    assign addr_ok   = {1'b0, sel.sel_addr} < (ADDR_W+1)'(N_PROJ);
    assign is_active = (state_q == ST_ACTIVE);
    assign pass_in   = (state_q == ST_RESET) || is_active;
    assign cur_addr  = pass_in ? tgt_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ena_d   = ena_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (!sel.sel_en || !addr_ok) begin
                        err_d   = sel.sel_en;
                        state_d = ST_IDLE;
                        ena_d   = '0;
                        tgt_d   = '0;
                    end else if (!(is_active && sel.sel_addr == tgt_q)) begin
                        // Re-selecting the running project is a no-op; anything
                        // else drops ena first so old and new never overlap.
                        state_d = ST_ISOLATE;
                        cnt_d   = ISO_LOAD;
                        tgt_d   = sel.sel_addr;
                        ena_d   = '0;
                    end
                end
            end
            ST_ISOLATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                    for (int i = 0; i < N_PROJ; i++) begin
                        ena_d[i] = (tgt_q == ADDR_W'(i));
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESET: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ena_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ena_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ena_q   <= ena_d;
            err_q   <= err_d;
        end
    end

    // Pad inputs reach the projects only once one is enabled; the project
    // reset stays low until the sequence has reached ACTIVE.
    always_comb begin
        iw                   = '0;
        iw[IW_CLK]           = clk;
        iw[IW_RST]           = proj_rst_n && is_active;
        iw[IW_UI_LO  +: 8]   = pass_in ? ui_in  : 8'h00;
        iw[IW_UIO_LO +: 8]   = pass_in ? uio_in : 8'h00;
    end

    assign ena            = ena_q;
    assign sel.sel_ready  = ready;
    assign sel.sel_err    = err_q;
    assign sel.busy       = (state_q == ST_ISOLATE) || (state_q == ST_RESET);
    assign sel.cur_addr   = cur_addr;
    assign sel.cur_active = is_active;

    tt_mux_ow_sel #(
        .N_PROJ (N_PROJ),
        .ADDR_W (ADDR_W)
    ) u_ow_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_addr   (cur_addr),
        .sel_active (is_active),
        .ow_all     (ow_all),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe)
    );

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// tb/tb_tt_mux_ctrl.sv - self-checking bench for tt_mux_ctrl against a timeline model
module tb_tt_mux_ctrl;
    import tt_mux_pkg::*;

    localparam int N_PROJ = 32;
    localparam int ADDR_W = 6;
    localparam int ISO    = 4;
    localparam int RST    = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [7:0]             ui_in, uio_in;
    logic                   proj_rst_n;
    logic [IW_W-1:0]        iw;
    logic [N_PROJ-1:0]      ena;
    logic [OW_W*N_PROJ-1:0] ow_all;
    logic [7:0]             uo_out, uio_out, uio_oe;

    tt_mux_ctrl_if #(.ADDR_W(ADDR_W)) sif ();

    tt_mux_ctrl #(
        .N_PROJ     (N_PROJ),
        .ADDR_W     (ADDR_W),
        .ISO_CYCLES (ISO),
        .RST_CYCLES (RST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sif.slave),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .proj_rst_n (proj_rst_n),
        .iw         (iw),
        .ena        (ena),
        .ow_all     (ow_all),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a switch is a point in time (m_tacc); each phase follows from elapsed cycles.
    int            cyc = 0;
    bit            m_on = 1'b0;
    int            m_tgt = 0;
    int            m_tacc = 0;
    bit            m_err = 1'b0;
    logic [23:0]   m_out = '0;

    function automatic bit m_iso();
        return m_on && (cyc - m_tacc) < ISO;
    endfunction
    function automatic bit m_rst();
        return m_on && (cyc - m_tacc) >= ISO && (cyc - m_tacc) < ISO + RST;
    endfunction
    function automatic bit m_act();
        return m_on && (cyc - m_tacc) >= ISO + RST;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        logic [N_PROJ-1:0] e_ena;
        logic [IW_W-1:0]   e_iw;
        bit                pass;
        pass  = m_rst() || m_act();
        e_ena = pass ? (N_PROJ'(1) << m_tgt) : '0;
        e_iw  = {pass ? uio_in : 8'h00, pass ? ui_in : 8'h00, proj_rst_n && m_act(), 1'b1};
        chk("ena",        64'(ena),            64'(e_ena));
        chk("sel_ready",  64'(sif.sel_ready),  64'(!m_on || m_act()));
        chk("busy",       64'(sif.busy),       64'(m_iso() || m_rst()));
        chk("cur_active", 64'(sif.cur_active), 64'(m_act()));
        chk("cur_addr",   64'(sif.cur_addr),   pass ? 64'(m_tgt) : 64'd0);
        chk("sel_err",    64'(sif.sel_err),    64'(m_err));
        chk("iw",         64'(iw),             64'(e_iw));
        chk("outs",       64'({uio_oe, uio_out, uo_out}), 64'(m_out));
    endtask

    task automatic tick();
        bit          acc, was_act;
        logic [23:0] nxt;
        was_act = m_act();
        acc     = sif.sel_valid && (!m_on || was_act);
        nxt     = was_act ? ow_all[m_tgt*OW_W +: OW_W] : 24'h0;
        @(posedge clk);
        cyc++;
        if (acc) begin
            m_err = 1'b0;
            if (!sif.sel_en) begin
                m_on = 1'b0;
            end else if (int'(sif.sel_addr) >= N_PROJ) begin
                m_on  = 1'b0;
                m_err = 1'b1;
            end else if (!(was_act && int'(sif.sel_addr) == m_tgt)) begin
                m_on   = 1'b1;
                m_tgt  = int'(sif.sel_addr);
                m_tacc = cyc;
            end
        end
        m_out = nxt;
        #1;
        check_all();
    endtask

    task automatic request(input bit en, input int addr);
        sif.sel_valid = 1'b1;
        sif.sel_en    = en;
        sif.sel_addr  = ADDR_W'(addr);
        tick();
        sif.sel_valid = 1'b0;
    endtask

    // Called right after tick(), so clk is still high at each check.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        m_on  = 1'b0;
        m_err = 1'b0;
        m_out = '0;
        check_all();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        sif.sel_valid = 1'b0;
        sif.sel_en    = 1'b0;
        sif.sel_addr  = '0;
        ui_in         = 8'h5C;
        uio_in        = 8'hC3;
        proj_rst_n    = 1'b1;
        ow_all        = '0;
        for (int i = 0; i < N_PROJ; i++) ow_all[i*OW_W +: OW_W] = 24'(32'h10101 * (i + 1));

        // Reset values while rst_n is held low.
        #6;
        check_all();
        #1 rst_n = 1'b1;

        // First switch to project 3: 4 isolate cycles, 8 reset cycles, then active.
        request(1'b1, 3);
        repeat (14) tick();
        chk("active_on_3", 64'(ena), 64'h8);

        // Output mux follows slice 3 only.
        ow_all[3*OW_W +: OW_W] = 24'hA5_5A_3C;
        tick();
        tick();
        chk("uio_oe_A5",  64'(uio_oe),  64'hA5);
        chk("uio_out_5A", 64'(uio_out), 64'h5A);
        chk("uo_out_3C",  64'(uo_out),  64'h3C);
        for (int k = 0; k < 4; k++) begin
            ow_all[7*OW_W +: OW_W] = 24'($urandom);
            tick();
        end

        // Switch 3 -> 7.
        request(1'b1, 7);
        repeat (14) tick();
        chk("active_on_7", 64'(ena), 64'h80);

        // Hold a request for 9 while the switch to 2 is busy.
        request(1'b1, 2);
        sif.sel_valid = 1'b1;
        sif.sel_addr  = ADDR_W'(9);
        repeat (16) tick();
        sif.sel_valid = 1'b0;
        repeat (12) tick();
        chk("active_on_9", 64'(ena), 64'h200);
        request(1'b1, 9);
        repeat (3) tick();

        // Out-of-range address, then a valid request clears the flag.
        request(1'b1, 40);
        tick();
        chk("err_set", 64'(sif.sel_err), 64'h1);
        request(1'b1, 2);
        chk("err_clr", 64'(sif.sel_err), 64'h0);
        repeat (12) tick();

        // Disable all projects.
        request(1'b0, 0);
        tick();

        // Reset pulse in the middle of the RESET phase.
        request(1'b1, 5);
        repeat (6) tick();
        async_reset();
        repeat (2) tick();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            sif.sel_valid = ($urandom_range(0, 5) == 0);
            sif.sel_en    = ($urandom_range(0, 7) != 0);
            sif.sel_addr  = ADDR_W'($urandom_range(0, 47));
            ui_in         = 8'($urandom);
            uio_in        = 8'($urandom);
            proj_rst_n    = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_PROJ; i++) ow_all[i*OW_W +: OW_W] = 24'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
